// File: rtl/amba3_axi_rd_arbiter_if.sv
// Bus bundle for the AXI3 read arbiter: the upstream AR/R ports of all
// masters plus the single downstream AR/R port.
//   slave  : arbiter view (accepts upstream requests, drives downstream)
//   master : environment view (drives upstream requests, acts as the slave port)
interface amba3_axi_rd_arbiter_if #(
  parameter int NUM_M     = 4,
  parameter int TXID_SIZE = 4,
  parameter int ADDR_SIZE = 32,
  parameter int DATA_SIZE = 32
);
  localparam int IDX_W = $clog2(NUM_M);
  localparam int MID_W = TXID_SIZE + IDX_W;

  // upstream side
  logic [NUM_M*TXID_SIZE-1:0] s_arid;
  logic [NUM_M*ADDR_SIZE-1:0] s_araddr;
  logic [NUM_M*18-1:0]        s_arinfo;
  logic [NUM_M-1:0]           s_arvalid;
  logic [NUM_M-1:0]           s_arready;
  logic [TXID_SIZE-1:0]       s_rid;
  logic [DATA_SIZE-1:0]       s_rdata;
  logic [1:0]                 s_rresp;
  logic                       s_rlast;
  logic [NUM_M-1:0]           s_rvalid;
  logic [NUM_M-1:0]           s_rready;

  // downstream side
  logic [MID_W-1:0]           m_arid;
  logic [ADDR_SIZE-1:0]       m_araddr;
  logic [17:0]                m_arinfo;
  logic                       m_arvalid;
  logic                       m_arready;
  logic [MID_W-1:0]           m_rid;
  logic [DATA_SIZE-1:0]       m_rdata;
  logic [1:0]                 m_rresp;
  logic                       m_rlast;
  logic                       m_rvalid;
  logic                       m_rready;

  modport slave (
    input  s_arid, s_araddr, s_arinfo, s_arvalid, s_rready,
    input  m_arready, m_rid, m_rdata, m_rresp, m_rlast, m_rvalid,
    output s_arready, s_rid, s_rdata, s_rresp, s_rlast, s_rvalid,
    output m_arid, m_araddr, m_arinfo, m_arvalid, m_rready
  );

  modport master (
    output s_arid, s_araddr, s_arinfo, s_arvalid, s_rready,
    output m_arready, m_rid, m_rdata, m_rresp, m_rlast, m_rvalid,
    input  s_arready, s_rid, s_rdata, s_rresp, s_rlast, s_rvalid,
    input  m_arid, m_araddr, m_arinfo, m_arvalid, m_rready
  );
endinterface

// File: rtl/amba3_axi_rd_arbiter.sv
// AXI3 read-port arbiter: NUM_M masters share one AR/R port.
// AR: round-robin grant into a single registered output stage, master index
// prepended to ARID. R: beats routed back by the upper RID bits; beats with
// an out-of-range index are sunk and flagged in err_rid (sticky).
// Optional: AMBA3_AXI_RD_ARB_LOCKED_EN -- a LOCKED (lock==2'b10) grant pins
// arbitration to its master until that master issues a non-locked request.

// Per-master outstanding-burst counter. Simultaneous inc/dec cancel.
module amba3_axi_rd_arbiter_cnt #(
  parameter int CNT_W = 3
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [CNT_W-1:0] o_cnt
);
  logic [CNT_W-1:0] r_cnt;

  // count AR handshakes up, last R beats down
  always_ff @(posedge aclk or posedge areset) begin
    if (areset)                              r_cnt <= '0;
    else if (i_inc && !i_dec)                r_cnt <= r_cnt + 1'b1;
    else if (!i_inc && i_dec && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
  end

  assign o_cnt = r_cnt;
endmodule

module amba3_axi_rd_arbiter #(
  parameter int NUM_M     = 4,
  parameter int TXID_SIZE = 4,
  parameter int ADDR_SIZE = 32,
  parameter int DATA_SIZE = 32,
  parameter int MAX_OUTST = 4
) (
  input  logic                  aclk,
  input  logic                  areset,
  amba3_axi_rd_arbiter_if.slave bus,
  output logic                  err_rid
);
  localparam int IDX_W = $clog2(NUM_M);
  localparam int MID_W = TXID_SIZE + IDX_W;
  localparam int CNT_W = $clog2(MAX_OUTST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTST);

  // output stage
  logic                          r_arvalid;
  logic [MID_W-1:0]              r_arid;
  logic [ADDR_SIZE-1:0]          r_araddr;
  logic [17:0]                   r_arinfo;
  logic [IDX_W-1:0]              r_rr;
  logic                          r_err_rid;

  logic [NUM_M-1:0][CNT_W-1:0]   w_cnt;
  logic [NUM_M-1:0]              w_elig;
  logic [NUM_M-1:0]              w_inc;
  logic [NUM_M-1:0]              w_dec;
  logic [IDX_W-1:0]              w_win;
  logic [IDX_W-1:0]              w_rr_nxt;
  logic                          w_any;
  logic                          w_load;
  logic [TXID_SIZE-1:0]          w_sel_id;
  logic [ADDR_SIZE-1:0]          w_sel_addr;
  logic [17:0]                   w_sel_info;
  logic [IDX_W-1:0]              w_k;
  logic                          w_kok;
  logic                          w_rready;
  logic                          w_rlast_hs;

`ifdef AMBA3_AXI_RD_ARB_LOCKED_EN
  logic                          r_lock_active;
  logic [IDX_W-1:0]              r_lock_owner;
`endif

  // eligibility: valid request and room for another outstanding burst
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NUM_M; i++) begin
      w_elig[i] = bus.s_arvalid[i] && (w_cnt[i] < CNT_MAX);
`ifdef AMBA3_AXI_RD_ARB_LOCKED_EN
      if (r_lock_active && (r_lock_owner != IDX_W'(i))) w_elig[i] = 1'b0;
`endif
    end
  end

  // round-robin search starting at r_rr; first eligible index wins
  always_comb begin
    int j;
    j     = 0;
    w_win = r_rr;
    w_any = 1'b0;
    for (int off = 0; off < NUM_M; off++) begin
      j = int'(r_rr) + off;
      if (j >= NUM_M) j = j - NUM_M;
      if (!w_any && w_elig[IDX_W'(j)]) begin
        w_any = 1'b1;
        w_win = IDX_W'(j);
      end
    end
  end

  assign w_load   = (!r_arvalid || bus.m_arready) && w_any;
  assign w_rr_nxt = (w_win == IDX_W'(NUM_M - 1)) ? '0 : w_win + 1'b1;

  // winner payload mux and one-hot ready back to the winner only
  always_comb begin
    w_sel_id      = '0;
    w_sel_addr    = '0;
    w_sel_info    = '0;
    bus.s_arready = '0;
    w_inc         = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (w_win == IDX_W'(i)) begin
        w_sel_id   = bus.s_arid[i*TXID_SIZE +: TXID_SIZE];
        w_sel_addr = bus.s_araddr[i*ADDR_SIZE +: ADDR_SIZE];
        w_sel_info = bus.s_arinfo[i*18 +: 18];
        w_inc[i]   = w_load;
        // reset must kill the ready path immediately, not at the next edge
        bus.s_arready[i] = w_load && !areset;
      end
    end
  end

  // output register: load on grant, drop valid on drain, hold under stall
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_arvalid <= 1'b0;
      r_arid    <= '0;
      r_araddr  <= '0;
      r_arinfo  <= '0;
      r_rr      <= '0;
    end else if (w_load) begin
      r_arvalid <= 1'b1;
      r_arid    <= {w_win, w_sel_id};
      r_araddr  <= w_sel_addr;
      r_arinfo  <= w_sel_info;
      r_rr      <= w_rr_nxt;
    end else if (bus.m_arready) begin
      r_arvalid <= 1'b0;
    end
  end

`ifdef AMBA3_AXI_RD_ARB_LOCKED_EN
  // lock tracking: a LOCKED grant pins arbitration to its master
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_lock_active <= 1'b0;
      r_lock_owner  <= '0;
    end else if (w_load) begin
      if (w_sel_info[8:7] == 2'b10) begin
        r_lock_active <= 1'b1;
        r_lock_owner  <= w_win;
      end else if (r_lock_active && (w_win == r_lock_owner)) begin
        r_lock_active <= 1'b0;
      end
    end
  end
`endif

  assign bus.m_arvalid = r_arvalid;
  assign bus.m_arid    = r_arid;
  assign bus.m_araddr  = r_araddr;
  assign bus.m_arinfo  = r_arinfo;

  // R routing: index in the top RID bits selects the owning master
  assign w_k = bus.m_rid[MID_W-1:TXID_SIZE];

  generate
    if ((1 << IDX_W) == NUM_M) begin : g_kfull
      assign w_kok = 1'b1;
    end else begin : g_kchk
      assign w_kok = (w_k < IDX_W'(NUM_M));
    end
  endgenerate

  // steer valid to the owner, take its ready; unknown index is sunk
  always_comb begin
    bus.s_rvalid = '0;
    w_rready     = !w_kok;
    for (int i = 0; i < NUM_M; i++) begin
      if (w_kok && (w_k == IDX_W'(i))) begin
        bus.s_rvalid[i] = bus.m_rvalid;
        w_rready        = bus.s_rready[i];
      end
    end
  end

  assign bus.m_rready = w_rready;
  assign bus.s_rid    = bus.m_rid[TXID_SIZE-1:0];
  assign bus.s_rdata  = bus.m_rdata;
  assign bus.s_rresp  = bus.m_rresp;
  assign bus.s_rlast  = bus.m_rlast;

  assign w_rlast_hs = bus.m_rvalid && w_rready && bus.m_rlast;

  // burst completion decrements the owner's counter
  always_comb begin
    w_dec = '0;
    for (int i = 0; i < NUM_M; i++)
      w_dec[i] = w_rlast_hs && w_kok && (w_k == IDX_W'(i));
  end

  amba3_axi_rd_arbiter_cnt #(.CNT_W(CNT_W)) u_cnt [NUM_M-1:0] (
    .aclk   (aclk),
    .areset (areset),
    .i_inc  (w_inc),
    .i_dec  (w_dec),
    .o_cnt  (w_cnt)
  );

  // sticky flag for R beats carrying an index no master owns
  always_ff @(posedge aclk or posedge areset) begin
    if (areset)                      r_err_rid <= 1'b0;
    else if (bus.m_rvalid && !w_kok) r_err_rid <= 1'b1;
  end

  assign err_rid = r_err_rid;
endmodule
